operand_issue_stage: RTL

Issue stage between the instruction decoder and the execute stage of the core. It drives the register file read addresses and captures the two source operands into an output pipeline register. A 32-bit scoreboard stalls instructions on RAW/WAW hazards against in-flight writes, and writeback data is bypassed in the same cycle it is written to the register file.

---
 rtl/operand_issue_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/operand_issue_stage.sv
// Issue stage: reads source operands (with writeback bypass), tracks in-flight writes in a
// scoreboard, and holds the issued instruction in a valid/ready output register.
module operand_issue_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [REG_ADDR_W-1:0] inRs1,
  input  logic [REG_ADDR_W-1:0] inRs2,
  input  logic                  inUseRs1,
  input  logic                  inUseRs2,
  input  logic [REG_ADDR_W-1:0] inRd,
  input  logic                  inWritesRd,
  input  logic [31:0]           inCtrl,
  output logic [REG_ADDR_W-1:0] rfReadAddress1,
  output logic [REG_ADDR_W-1:0] rfReadAddress2,
  input  logic [XLEN-1:0]       rfReadData1,
  input  logic [XLEN-1:0]       rfReadData2,
  input  logic                  wbValid,
  input  logic [REG_ADDR_W-1:0] wbAddress,
  input  logic [XLEN-1:0]       wbData,
  input  logic                  flush,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [XLEN-1:0]       outOperand1,
  output logic [XLEN-1:0]       outOperand2,
  output logic [REG_ADDR_W-1:0] outRd,
  output logic                  outWritesRd,
  output logic [31:0]           outCtrl
);

  localparam int unsigned NumRegs = 1 << REG_ADDR_W;

  logic [NumRegs-1:0]    busy_q, busy_d;
  logic                  out_valid_q, out_valid_d;
  logic [XLEN-1:0]       out_op1_q, out_op1_d;
  logic [XLEN-1:0]       out_op2_q, out_op2_d;
  logic [REG_ADDR_W-1:0] out_rd_q, out_rd_d;
  logic                  out_writes_rd_q, out_writes_rd_d;
  logic [31:0]           out_ctrl_q, out_ctrl_d;

  logic                  rs1_zero, rs2_zero, rd_zero;
  logic                  byp1, byp2, byp_rd;
  logic                  raw_hazard, waw_hazard;
  logic                  accept;
  logic [XLEN-1:0]       op1, op2;

  assign rfReadAddress1 = inRs1;
  assign rfReadAddress2 = inRs2;

  always_comb begin
    rs1_zero = (inRs1 == '0);
    rs2_zero = (inRs2 == '0);
    rd_zero  = (inRd == '0);
    byp1     = wbValid && (wbAddress == inRs1);
    byp2     = wbValid && (wbAddress == inRs2);
    byp_rd   = wbValid && (wbAddress == inRd);

    if (!inUseRs1 || rs1_zero) op1 = '0;
    else if (byp1)             op1 = wbData;
    else                       op1 = rfReadData1;

    if (!inUseRs2 || rs2_zero) op2 = '0;
    else if (byp2)             op2 = wbData;
    else                       op2 = rfReadData2;

    // A producer writing back this cycle no longer blocks its consumer.
    raw_hazard = (inUseRs1 && !rs1_zero && busy_q[inRs1] && !byp1) ||
                 (inUseRs2 && !rs2_zero && busy_q[inRs2] && !byp2);
    waw_hazard = inWritesRd && !rd_zero && busy_q[inRd] && !byp_rd;

    inReady = !rst && !flush && !raw_hazard && !waw_hazard && (!out_valid_q || outReady);
    accept  = inValid && inReady;
  end

  always_comb begin
    busy_d          = busy_q;
    out_valid_d     = out_valid_q;
    out_op1_d       = out_op1_q;
    out_op2_d       = out_op2_q;
    out_rd_d        = out_rd_q;
    out_writes_rd_d = out_writes_rd_q;
    out_ctrl_d      = out_ctrl_q;

    if (wbValid) busy_d[wbAddress] = 1'b0;
    if (flush && out_valid_q && out_writes_rd_q && (out_rd_q != '0)) busy_d[out_rd_q] = 1'b0;
    // Set after clear so a same-cycle set wins.
    if (accept && inWritesRd && !rd_zero) busy_d[inRd] = 1'b1;
    busy_d[0] = 1'b0;

    if (accept) begin
      out_valid_d     = 1'b1;
      out_op1_d       = op1;
      out_op2_d       = op2;
      out_rd_d        = inRd;
      out_writes_rd_d = inWritesRd;
      out_ctrl_d      = inCtrl;
    end else if (flush || outReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q          <= '0;
      out_valid_q     <= 1'b0;
      out_op1_q       <= '0;
      out_op2_q       <= '0;
      out_rd_q        <= '0;
      out_writes_rd_q <= 1'b0;
      out_ctrl_q      <= '0;
    end else begin
      busy_q          <= busy_d;
      out_valid_q     <= out_valid_d;
      out_op1_q       <= out_op1_d;
      out_op2_q       <= out_op2_d;
      out_rd_q        <= out_rd_d;
      out_writes_rd_q <= out_writes_rd_d;
      out_ctrl_q      <= out_ctrl_d;
    end
  end

  assign outValid    = out_valid_q;
  assign outOperand1 = out_op1_q;
  assign outOperand2 = out_op2_q;
  assign outRd       = out_rd_q;
  assign outWritesRd = out_writes_rd_q;
  assign outCtrl     = out_ctrl_q;

endmodule
